pipelined_ctrl_unit: RTL and testbench
======================================

Name: pipelined_ctrl_unit

Overview:
Next-generation instruction decode controller for the 5-stage MIPS core. It decodes opcode/func in ID and registers the full control bundle into the ID/EX boundary. Registration supports stall (bubble insert) and flush. It adds a multi-cycle MULT/DIV occupancy tracker that raises an ID stall on HI/LO structural and data hazards, plus an illegal-instruction flag.

Parameters:
ALUOP_W, 4, width of the ALU op field; ALU_* codes come from controller_constants.vh and are zero-extended to ALUOP_W.
MULDIV_LAT, 4, EX-unit occupancy in cycles for MULT/DIV; legal range 1..15.
ENABLE_MULDIV, 1, 0 = MULT/DIV/MFHI/MFLO decode as illegal and the tracker is never armed.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
opcode  in  6  instr[31:26]
func  in  6  instr[5:0]
stall_in  in  1  load-use stall from hazard unit
flush_in  in  1  branch/jump flush of the ID instruction
id_stall  out  1  combinational; MULDIV hazard, holds PC and IF/ID
muldiv_busy  out  1  registered; tracker in BUSY
ex_valid  out  1  EX holds a real instruction
ex_aluop  out  ALUOP_W  ALU operation
ex_alusrc  out  1  1 = immediate operand
ex_regdst  out  1  1 = rd, 0 = rt
ex_regwrite  out  1  register file write
ex_writemem  out  1  data memory write
ex_readmem  out  1  data memory read
ex_memtoreg  out  1  writeback from memory
ex_shift  out  2  0 none, 1 shamt shift, 2 LUI (imm<<16)
ex_branch  out  3  0 none, 1 BEQ, 2 BNE, 3 BGTZ, 4 BGEZ
ex_jump  out  2  0 none, 1 J, 2 JAL, 3 JR
ex_muldiv  out  1  EX issues MULT/DIV
ex_illegal  out  1  unrecognised opcode/func with id_valid

Behaviour:
- Reset (rst_n=0, async): all ex_* = 0, ex_aluop = ALU_NOP, tracker IDLE, counter 0, muldiv_busy = 0.
- Decode (combinational), opcodes:
  - R = 0x00
  - ADDI 0x08 and ADDIU 0x09 -> ADD
  - SLTI 0x0A -> SLT
  - ANDI 0x0C -> AND
  - ORI 0x0D -> OR
  - LUI 0x0F -> SLL, shift = 2
  - LW 0x23 -> ADD, readmem = 1, memtoreg = 1
  - SW 0x2B -> ADD, writemem = 1, regwrite = 0
  - BEQ 0x04, BNE 0x05, BGTZ 0x07, BGEZ 0x01 -> NOP, regwrite = 0
  - J 0x02 -> regwrite = 0
  - JAL 0x03 -> regwrite = 1
- Decode, R-type func:
  - ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23, AND 0x24, OR 0x25, NOR 0x27, SLT 0x2A
  - SLL 0x00, SRL 0x02, SRA 0x03 -> shift = 1
  - JR 0x08 -> jump = 3, regwrite = 0
  - MFHI 0x10, MFLO 0x12 -> regwrite = 1
  - MULT 0x18, DIV 0x1A -> muldiv = 1, regwrite = 0
  - Every R-type sets regdst = 1.
- readmem is 1 only for LW.
- Unlisted opcode/func: all controls 0 and illegal = 1. An illegal instruction is a valid bubble: ex_valid = 1 with no side-effect controls.
- id_valid = 0: decode output is an all-zero bubble and illegal = 0.
- id_stall = id_valid & muldiv_busy & (decoded MULT/DIV/MFHI/MFLO). id_stall is independent of flush_in and stall_in.
- accept = id_valid & ~flush_in & ~stall_in & ~id_stall.
- ID/EX register, per rising edge:
  - accept = 1: loads the decoded bundle, ex_valid = 1.
  - otherwise: loads a bubble (all 0, aluop = ALU_NOP, ex_valid = 0).
  - Latency is 1 cycle from ID to ex_*.
- MULDIV tracker FSM:
  - IDLE -> BUSY when accept & decoded MULT/DIV; counter loads MULDIV_LAT-1.
  - BUSY: counter decrements each cycle, independent of stall and flush. At counter = 0, the next state is IDLE.
  - With MULDIV_LAT = 1, BUSY lasts exactly one cycle.
  - muldiv_busy = (state == BUSY).
  - The counter is not re-armed while BUSY; any MULT/DIV arriving while BUSY is held by id_stall.
- Simultaneous events:
  - flush_in with MULT/DIV in ID: no bubble is issued into the tracker and it is not armed.
  - flush_in while BUSY: the tracker keeps counting, because the issued MULT/DIV is already past ID.
  - Reset mid-BUSY: returns to IDLE immediately.

Test Plan:
1. Reset release, then id_valid = 1, opcode 0x23 -> next cycle ex_valid = 1, aluop = ALU_ADD, alusrc = 1, readmem = 1, memtoreg = 1, regwrite = 1, regdst = 0.
2. ORI (0x0D) then LUI (0x0F) back-to-back -> ex_readmem = 0 both cycles; LUI gives ex_shift = 2, aluop = ALU_SLL.
3. MULT (op 0x00, func 0x18), then MFLO (func 0x12) held in ID, MULDIV_LAT = 4:
   - muldiv_busy = 1 for 4 cycles.
   - id_stall = 1 for those 4 cycles, with ex_valid = 0 bubbles.
   - MFLO is issued on the cycle after busy drops.
4. ADD during BUSY -> id_stall = 0 and ADD is issued with no bubble.
5. flush_in = 1 with BEQ (0x04) in ID -> ex bubble, ex_branch = 0. stall_in = 1 with ADD -> bubble, and ADD is issued the cycle stall_in drops.
6. Opcode 0x3F -> ex_illegal = 1, ex_regwrite = 0. rst_n pulsed low mid-BUSY -> all outputs 0 asynchronously, muldiv_busy = 0. ENABLE_MULDIV = 0 with MULT -> ex_illegal = 1 and the tracker stays idle.

Source files
------------

// File: rtl/pipelined_ctrl_unit.sv
// pipelined_ctrl_unit: ID-stage decode, ID/EX control register and MULT/DIV occupancy tracker
module pipelined_ctrl_unit #(
   parameter int ALUOP_W       = 4,
   parameter int MULDIV_LAT    = 4,
   parameter bit ENABLE_MULDIV = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [5:0]         opcode,
   input  logic [5:0]         func,
   input  logic               stall_in,
   input  logic               flush_in,
   output logic               id_stall,
   output logic               muldiv_busy,
   output logic               ex_valid,
   output logic [ALUOP_W-1:0] ex_aluop,
   output logic               ex_alusrc,
   output logic               ex_regdst,
   output logic               ex_regwrite,
   output logic               ex_writemem,
   output logic               ex_readmem,
   output logic               ex_memtoreg,
   output logic [1:0]         ex_shift,
   output logic [2:0]         ex_branch,
   output logic [1:0]         ex_jump,
   output logic               ex_muldiv,
   output logic               ex_illegal
);
   // ALU_NOP is zero so an all-zero bundle is a clean bubble
   localparam logic [ALUOP_W-1:0] ALU_NOP = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(8);
   localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(9);

   typedef struct packed {
      logic               valid;
      logic [ALUOP_W-1:0] aluop;
      logic               alusrc;
      logic               regdst;
      logic               regwrite;
      logic               writemem;
      logic               readmem;
      logic               memtoreg;
      logic [1:0]         shift;
      logic [2:0]         branch;
      logic [1:0]         jump;
      logic               muldiv;
      logic               illegal;
   } ctrl_t;

   typedef enum logic {IDLE, BUSY} state_t;

   ctrl_t  dec, ex_d, ex_q;
   logic   dec_hilo, bad, accept;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   // Decode opcode/func into the control bundle; anything unrecognised becomes an illegal bubble
   always_comb begin
      dec       = '0;
      dec.aluop = ALU_NOP;
      dec_hilo  = 1'b0;
      bad       = 1'b0;
      if (id_valid) begin
         dec.valid = 1'b1;
         case (opcode)
            6'h00: begin
               dec.regdst   = 1'b1;
               dec.regwrite = 1'b1;
               case (func)
                  6'h20, 6'h21: dec.aluop = ALU_ADD;
                  6'h22, 6'h23: dec.aluop = ALU_SUB;
                  6'h24: dec.aluop = ALU_AND;
                  6'h25: dec.aluop = ALU_OR;
                  6'h27: dec.aluop = ALU_NOR;
                  6'h2A: dec.aluop = ALU_SLT;
                  6'h00: begin dec.aluop = ALU_SLL; dec.shift = 2'd1; end
                  6'h02: begin dec.aluop = ALU_SRL; dec.shift = 2'd1; end
                  6'h03: begin dec.aluop = ALU_SRA; dec.shift = 2'd1; end
                  6'h08: begin dec.jump = 2'd3; dec.regwrite = 1'b0; end
                  6'h10, 6'h12: begin dec_hilo = 1'b1; bad = ~ENABLE_MULDIV; end
                  6'h18, 6'h1A: begin
                     dec.muldiv   = 1'b1;
                     dec.regwrite = 1'b0;
                     bad          = ~ENABLE_MULDIV;
                  end
                  default: bad = 1'b1;
               endcase
            end
            6'h08, 6'h09: begin dec.aluop = ALU_ADD; dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
            6'h0A: begin dec.aluop = ALU_SLT; dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
            6'h0C: begin dec.aluop = ALU_AND; dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
            6'h0D: begin dec.aluop = ALU_OR;  dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
            6'h0F: begin
               dec.aluop    = ALU_SLL;
               dec.alusrc   = 1'b1;
               dec.regwrite = 1'b1;
               dec.shift    = 2'd2;
            end
            6'h23: begin
               dec.aluop    = ALU_ADD;
               dec.alusrc   = 1'b1;
               dec.regwrite = 1'b1;
               dec.readmem  = 1'b1;
               dec.memtoreg = 1'b1;
            end
            6'h2B: begin dec.aluop = ALU_ADD; dec.alusrc = 1'b1; dec.writemem = 1'b1; end
            6'h04: dec.branch = 3'd1;
            6'h05: dec.branch = 3'd2;
            6'h07: dec.branch = 3'd3;
            6'h01: dec.branch = 3'd4;
            6'h02: dec.jump = 2'd1;
            6'h03: begin dec.jump = 2'd2; dec.regwrite = 1'b1; end
            default: bad = 1'b1;
         endcase
      end
      if (bad) begin
         dec         = '0;
         dec.aluop   = ALU_NOP;
         dec.valid   = 1'b1;
         dec.illegal = 1'b1;
         dec_hilo    = 1'b0;
      end
   end

   assign muldiv_busy = (state_q == BUSY);
   assign id_stall    = id_valid & muldiv_busy & (dec.muldiv | dec_hilo);
   assign accept      = id_valid & ~flush_in & ~stall_in & ~id_stall;

   // Next ID/EX contents: the decoded bundle when accepted, otherwise a bubble
   always_comb begin
      ex_d = accept ? dec : '0;
   end

   // Tracker next state: arm on an accepted MULT/DIV, count down while BUSY regardless of stall/flush
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         state_d = (accept & dec.muldiv) ? BUSY : IDLE;
         cnt_d   = (accept & dec.muldiv) ? 4'(MULDIV_LAT - 1) : cnt_q;
      end else begin
         state_d = (cnt_q == 4'd0) ? IDLE : BUSY;
         cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      end
   end

   // ID/EX control register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   // MULT/DIV occupancy tracker state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_valid    = ex_q.valid;
   assign ex_aluop    = ex_q.aluop;
   assign ex_alusrc   = ex_q.alusrc;
   assign ex_regdst   = ex_q.regdst;
   assign ex_regwrite = ex_q.regwrite;
   assign ex_writemem = ex_q.writemem;
   assign ex_readmem  = ex_q.readmem;
   assign ex_memtoreg = ex_q.memtoreg;
   assign ex_shift    = ex_q.shift;
   assign ex_branch   = ex_q.branch;
   assign ex_jump     = ex_q.jump;
   assign ex_muldiv   = ex_q.muldiv;
   assign ex_illegal  = ex_q.illegal;
endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// tb_pipelined_ctrl_unit: table vectors, directed multi-cycle sequences and random stimulus vs a reference model
module tb_pipelined_ctrl_unit;
   localparam int NOP = 0, ADD = 1, SUB = 2, AND_ = 3, OR_ = 4, NOR_ = 5, SLT = 6, SLL = 7, SRL = 8, SRA = 9;

   typedef struct packed {
      logic       valid;
      logic [3:0] aluop;
      logic       alusrc;
      logic       regdst;
      logic       regwrite;
      logic       writemem;
      logic       readmem;
      logic       memtoreg;
      logic [1:0] shift;
      logic [2:0] branch;
      logic [1:0] jump;
      logic       muldiv;
      logic       illegal;
   } bundle_t;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] fn;
      logic       v;
      logic       st;
      logic       fl;
      bundle_t    exp;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, stall_in = 1'b0, flush_in = 1'b0;
   logic [5:0] opcode = 6'h00, func = 6'h00;
   bundle_t got [3];
   logic stl [3];
   logic bsy [3];

   always #5 clk = ~clk;

   // instance 0: defaults, 1: MULT/DIV disabled, 2: single-cycle occupancy
   for (genvar k = 0; k < 3; k++) begin : g
      logic s, b, v, asrc, rdst, rw, wm, rm, m2r, md, il;
      logic [3:0] al;
      logic [1:0] sh, jp;
      logic [2:0] br;
      pipelined_ctrl_unit #(.ALUOP_W(4), .MULDIV_LAT(k == 2 ? 1 : 4), .ENABLE_MULDIV(k != 1)) u (
         .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .func(func),
         .stall_in(stall_in), .flush_in(flush_in), .id_stall(s), .muldiv_busy(b),
         .ex_valid(v), .ex_aluop(al), .ex_alusrc(asrc), .ex_regdst(rdst), .ex_regwrite(rw),
         .ex_writemem(wm), .ex_readmem(rm), .ex_memtoreg(m2r), .ex_shift(sh), .ex_branch(br),
         .ex_jump(jp), .ex_muldiv(md), .ex_illegal(il)
      );
      assign got[k] = {v, al, asrc, rdst, rw, wm, rm, m2r, sh, br, jp, md, il};
      assign stl[k] = s;
      assign bsy[k] = b;
   end

   int n_chk = 0, n_fail = 0;
   int left [3] = '{0, 0, 0};
   bundle_t exp_q [3] = '{'0, '0, '0};

   function automatic int lat_of(int k);
      return k == 2 ? 1 : 4;
   endfunction

   function automatic bit en_of(int k);
      return k != 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   function automatic bundle_t mkb(int v, int al, int src, int dst, int rw, int wm, int rm, int m2r,
                                   int sh, int br, int jp, int md, int il);
      bundle_t b;
      b = {1'(v), 4'(al), 1'(src), 1'(dst), 1'(rw), 1'(wm), 1'(rm), 1'(m2r), 2'(sh), 3'(br), 2'(jp), 1'(md), 1'(il)};
      return b;
   endfunction

   function automatic bit is_hilo(logic [5:0] op, logic [5:0] fn, bit en);
      return en && op == 6'h00 && (fn == 6'h10 || fn == 6'h12);
   endfunction

   // Reference decode straight from the instruction table
   function automatic bundle_t ref_dec(logic [5:0] op, logic [5:0] fn, bit en);
      bundle_t b;
      bit ok = 1'b1;
      b = mkb(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (op == 6'h00) begin
         b.regdst = 1'b1;
         b.regwrite = 1'b1;
         case (fn)
            6'h20, 6'h21: b.aluop = 4'(ADD);
            6'h22, 6'h23: b.aluop = 4'(SUB);
            6'h24: b.aluop = 4'(AND_);
            6'h25: b.aluop = 4'(OR_);
            6'h27: b.aluop = 4'(NOR_);
            6'h2A: b.aluop = 4'(SLT);
            6'h00, 6'h02, 6'h03: begin
               b.aluop = fn == 6'h00 ? 4'(SLL) : fn == 6'h02 ? 4'(SRL) : 4'(SRA);
               b.shift = 2'd1;
            end
            6'h08: begin b.jump = 2'd3; b.regwrite = 1'b0; end
            6'h10, 6'h12: ok = en;
            6'h18, 6'h1A: begin b.muldiv = 1'b1; b.regwrite = 1'b0; ok = en; end
            default: ok = 1'b0;
         endcase
      end else begin
         case (op)
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: begin
               b.alusrc = 1'b1;
               b.regwrite = op != 6'h2B;
               b.aluop = op == 6'h0A ? 4'(SLT) : op == 6'h0C ? 4'(AND_) : op == 6'h0D ? 4'(OR_) :
                         op == 6'h0F ? 4'(SLL) : 4'(ADD);
               b.shift = op == 6'h0F ? 2'd2 : 2'd0;
               b.readmem = op == 6'h23;
               b.memtoreg = op == 6'h23;
               b.writemem = op == 6'h2B;
            end
            6'h04: b.branch = 3'd1;
            6'h05: b.branch = 3'd2;
            6'h07: b.branch = 3'd3;
            6'h01: b.branch = 3'd4;
            6'h02: b.jump = 2'd1;
            6'h03: begin b.jump = 2'd2; b.regwrite = 1'b1; end
            default: ok = 1'b0;
         endcase
      end
      if (!ok) b = mkb(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      return b;
   endfunction

   // One ID cycle: drive, check id_stall, clock, then check ex_* and busy against the model
   task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic v, input logic st,
                       input logic fl, output logic s0);
      bit acc [3];
      bit hz;
      bundle_t d [3];
      id_valid = v; opcode = op; func = fn; stall_in = st; flush_in = fl;
      #1;
      for (int k = 0; k < 3; k++) begin
         d[k] = ref_dec(op, fn, en_of(k));
         hz = v && left[k] > 0 && (d[k].muldiv || is_hilo(op, fn, en_of(k)));
         chk($sformatf("id_stall[%0d] op=%0h fn=%0h", k, op, fn), 32'(stl[k]), 32'(hz));
         acc[k] = v && !fl && !st && !hz;
      end
      s0 = stl[0];
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         exp_q[k] = acc[k] ? d[k] : '0;
         if (left[k] > 0) left[k]--;
         else if (acc[k] && d[k].muldiv) left[k] = lat_of(k);
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("ex_bundle[%0d] op=%0h fn=%0h", k, op, fn), 32'(got[k]), 32'(exp_q[k]));
         chk($sformatf("muldiv_busy[%0d]", k), 32'(bsy[k]), 32'(left[k] > 0));
      end
   endtask

   vec_t tbl [$];
   logic sx;

   function automatic vec_t mkv(string nm, logic [5:0] op, logic [5:0] fn, logic v, logic st, logic fl, bundle_t e);
      vec_t r;
      r.name = nm; r.op = op; r.fn = fn; r.v = v; r.st = st; r.fl = fl; r.exp = e;
      return r;
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] ops [19] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23,
                                6'h2B, 6'h04, 6'h05, 6'h07, 6'h01, 6'h02, 6'h03, 6'h3F, 6'h11};
      logic [5:0] fns [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00,
                                6'h02, 6'h03, 6'h08, 6'h10, 6'h12, 6'h18, 6'h1A, 6'h18, 6'h3F};
      int cnt_stall, cnt_bub;

      tbl.push_back(mkv("LW",    6'h23, 6'h15, 1, 0, 0, mkb(1, ADD, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("ORI",   6'h0D, 6'h15, 1, 0, 0, mkb(1, OR_, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("LUI",   6'h0F, 6'h15, 1, 0, 0, mkb(1, SLL, 1, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0)));
      tbl.push_back(mkv("ADDI",  6'h08, 6'h15, 1, 0, 0, mkb(1, ADD, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("ADDIU", 6'h09, 6'h15, 1, 0, 0, mkb(1, ADD, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("SLTI",  6'h0A, 6'h15, 1, 0, 0, mkb(1, SLT, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("ANDI",  6'h0C, 6'h15, 1, 0, 0, mkb(1, AND_, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("SW",    6'h2B, 6'h15, 1, 0, 0, mkb(1, ADD, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("BEQ",   6'h04, 6'h15, 1, 0, 0, mkb(1, NOP, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)));
      tbl.push_back(mkv("BNE",   6'h05, 6'h15, 1, 0, 0, mkb(1, NOP, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0)));
      tbl.push_back(mkv("BGTZ",  6'h07, 6'h15, 1, 0, 0, mkb(1, NOP, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0)));
      tbl.push_back(mkv("BGEZ",  6'h01, 6'h15, 1, 0, 0, mkb(1, NOP, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0)));
      tbl.push_back(mkv("J",     6'h02, 6'h15, 1, 0, 0, mkb(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
      tbl.push_back(mkv("JAL",   6'h03, 6'h15, 1, 0, 0, mkb(1, NOP, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0)));
      tbl.push_back(mkv("ADD",   6'h00, 6'h20, 1, 0, 0, mkb(1, ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("ADDU",  6'h00, 6'h21, 1, 0, 0, mkb(1, ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("SUB",   6'h00, 6'h22, 1, 0, 0, mkb(1, SUB, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("SUBU",  6'h00, 6'h23, 1, 0, 0, mkb(1, SUB, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("AND",   6'h00, 6'h24, 1, 0, 0, mkb(1, AND_, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("OR",    6'h00, 6'h25, 1, 0, 0, mkb(1, OR_, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("NOR",   6'h00, 6'h27, 1, 0, 0, mkb(1, NOR_, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("SLT",   6'h00, 6'h2A, 1, 0, 0, mkb(1, SLT, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("SLL",   6'h00, 6'h00, 1, 0, 0, mkb(1, SLL, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0)));
      tbl.push_back(mkv("SRL",   6'h00, 6'h02, 1, 0, 0, mkb(1, SRL, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0)));
      tbl.push_back(mkv("SRA",   6'h00, 6'h03, 1, 0, 0, mkb(1, SRA, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0)));
      tbl.push_back(mkv("JR",    6'h00, 6'h08, 1, 0, 0, mkb(1, NOP, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0)));
      tbl.push_back(mkv("MFHI",  6'h00, 6'h10, 1, 0, 0, mkb(1, NOP, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("ILLOP", 6'h3F, 6'h20, 1, 0, 0, mkb(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
      tbl.push_back(mkv("ILLFN", 6'h00, 6'h3F, 1, 0, 0, mkb(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
      tbl.push_back(mkv("NOVAL", 6'h00, 6'h20, 0, 0, 0, mkb(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("FLBEQ", 6'h04, 6'h00, 1, 0, 1, mkb(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("STADD", 6'h00, 6'h20, 1, 1, 0, mkb(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv("FLMUL", 6'h00, 6'h18, 1, 0, 1, mkb(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

      // reset state
      #2;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_bundle[%0d]", k), 32'(got[k]), 32'd0);
         chk($sformatf("reset_busy[%0d]", k), 32'(bsy[k]), 32'd0);
      end
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // decode table
      foreach (tbl[i]) begin
         step(tbl[i].op, tbl[i].fn, tbl[i].v, tbl[i].st, tbl[i].fl, sx);
         chk({"tbl_", tbl[i].name}, 32'(got[0]), 32'(tbl[i].exp));
      end
      chk("flushed_mult_busy", 32'(bsy[0]), 32'd0);

      // MULT then MFLO held in ID
      step(6'h00, 6'h18, 1, 0, 0, sx);
      chk("mult_issue_muldiv", 32'(got[0].muldiv), 32'd1);
      chk("mult_busy", 32'(bsy[0]), 32'd1);
      chk("nomd_mult_illegal", 32'(got[1].illegal), 32'd1);
      chk("nomd_mult_busy", 32'(bsy[1]), 32'd0);
      chk("lat1_busy", 32'(bsy[2]), 32'd1);
      cnt_stall = 0; cnt_bub = 0;
      for (int i = 0; i < 20; i++) begin
         step(6'h00, 6'h12, 1, 0, 0, sx);
         if (sx) cnt_stall++;
         if (got[0].valid) break;
         cnt_bub++;
      end
      chk("mflo_stall_cycles", 32'(cnt_stall), 32'd4);
      chk("mflo_bubbles", 32'(cnt_bub), 32'd4);
      chk("mflo_regwrite", 32'(got[0].regwrite), 32'd1);
      chk("mflo_after_busy", 32'(bsy[0]), 32'd0);

      // ADD while BUSY passes straight through
      step(6'h00, 6'h1A, 1, 0, 0, sx);
      step(6'h00, 6'h20, 1, 0, 0, sx);
      chk("add_busy_nostall", 32'(sx), 32'd0);
      chk("add_busy_issue", 32'(got[0]), 32'(mkb(1, ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
      step(6'h00, 6'h20, 1, 0, 1, sx);
      chk("flush_while_busy", 32'(bsy[0]), 32'd1);
      for (int i = 0; i < 4; i++) step(6'h00, 6'h00, 0, 0, 0, sx);

      // stall_in then release
      step(6'h00, 6'h20, 1, 1, 0, sx);
      chk("stall_bubble", 32'(got[0].valid), 32'd0);
      step(6'h00, 6'h20, 1, 0, 0, sx);
      chk("stall_release_issue", 32'(got[0]), 32'(mkb(1, ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));

      // asynchronous reset mid-BUSY
      step(6'h00, 6'h18, 1, 0, 0, sx);
      step(6'h00, 6'h00, 0, 0, 0, sx);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("midbusy_reset_bundle[%0d]", k), 32'(got[k]), 32'd0);
         chk($sformatf("midbusy_reset_busy[%0d]", k), 32'(bsy[k]), 32'd0);
         left[k] = 0;
         exp_q[k] = '0;
      end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // random traffic against the model
      for (int i = 0; i < 500; i++) begin
         step(ops[$urandom_range(18)], fns[$urandom_range(17)], ($urandom % 8) != 0,
              ($urandom % 10) == 0, ($urandom % 10) == 0, sx);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
